enemy_hit_scanner: RTL and testbench
====================================

Name: enemy_hit_scanner

Overview:
- Time-multiplexed bullet-vs-enemy collision engine with per-enemy hit points; the parametrised successor to the single-cycle enemy alive controller.
- Once per frame it scans the enemies one per clock, compares each against all bullets in parallel, decrements hit points and retires dead enemies.
- It returns per-bullet hit flags to the bullet manager and a kill count to the score logic.
- Sits between the enemy movement block (positions), the bullet manager (positions, active flags) and the renderer/score logic (alive mask, kills).

Parameters:
ENEMY_COUNT, 17, number of enemies (1..64)
BULLET_COUNT, 8, number of bullet slots (1..32)
COORD_W, 10, coordinate width in pixels
ENEMY_W, 32, enemy hitbox width in pixels
ENEMY_H, 32, enemy hitbox height in pixels
HP_W, 2, hit-point counter width
HP_INIT, 1, hit points loaded on respawn (1..2^HP_W-1)

Ports:
clk25  in  1  25 MHz pixel clock
reset_n  in  1  asynchronous active-low reset
frame_tick  in  1  one-cycle pulse; starts a scan
respawn  in  1  one-cycle pulse; revive all enemies, load HP_INIT
bullet_x  in  BULLET_COUNT*COORD_W  bullet j x at [j*COORD_W +: COORD_W]
bullet_y  in  BULLET_COUNT*COORD_W  bullet j y, same packing
bullet_active  in  BULLET_COUNT  bullet j valid
enemy_x  in  ENEMY_COUNT*COORD_W  enemy i top-left x, packed as bullet_x
enemy_y  in  ENEMY_COUNT*COORD_W  enemy i top-left y
enemy_alive  out  ENEMY_COUNT  registered alive mask
bullet_hit  out  BULLET_COUNT  one-cycle per-bullet hit pulses, valid with scan_done
scan_done  out  1  one-cycle pulse at end of scan
kill_count  out  clog2(ENEMY_COUNT+1)  enemies killed this scan, valid with scan_done, held until next scan_done
busy  out  1  high while a scan is in progress
overrun  out  1  sticky: frame_tick arrived while busy; cleared by respawn

Behaviour:
- Reset (reset_n=0, asynchronous):
  - enemy_alive=0, all HP=0, bullet_hit=0, scan_done=0, kill_count=0, busy=0, overrun=0.
  - FSM enters IDLE.
  - The block is inert until the first respawn.
- FSM states: IDLE, SNAP, SCAN, DONE.
- IDLE: frame_tick -> SNAP.
- SNAP (1 cycle):
  - Latch bullet_x/bullet_y/bullet_active into internal snapshot registers.
  - Clear the consumed mask, the hit accumulator and the kill accumulator.
  - Set idx=0; busy=1.
- SCAN (exactly ENEMY_COUNT cycles, idx 0..ENEMY_COUNT-1):
  - If enemy idx is alive, test every snapshot bullet j that is active and not consumed.
  - Overlap test: x_e <= bx < x_e+ENEMY_W and y_e <= by < y_e+ENEMY_H.
  - Sums are computed at COORD_W+1 bits, so an enemy near the coordinate maximum never wraps.
  - Lowest-index overlapping bullet wins. Only that bullet is marked consumed and set in the accumulator. Other overlapping bullets remain free for later enemies.
  - On a win: HP[idx] decrements. If it reaches 0, enemy_alive[idx] clears and the kill accumulator increments.
  - An enemy takes at most one hit per scan.
  - Dead enemies are skipped, and bullets never hit them.
  - enemy_x/enemy_y are read live through an idx mux; the producer holds them stable while busy.
  - After idx=ENEMY_COUNT-1 -> DONE.
- DONE (1 cycle):
  - scan_done=1; bullet_hit = accumulator; kill_count = kill accumulator.
  - busy drops in this same cycle.
  - Next state: IDLE.
- Latency: frame_tick in cycle T gives scan_done in cycle T+ENEMY_COUNT+2.
- frame_tick while busy: ignored, overrun set (sticky).
- respawn, any state:
  - Next cycle enemy_alive = all ones and all HP = HP_INIT.
  - Any scan in progress is aborted: FSM -> IDLE, busy=0, no scan_done, no bullet_hit pulse; kill_count is unchanged.
  - overrun is cleared.
- respawn and frame_tick in the same cycle: respawn wins; frame_tick is dropped and does not set overrun.
- bullet_hit and scan_done are 0 in every cycle other than DONE.
- Asserting reset_n low mid-scan returns the block to its reset values immediately.

Test Plan:
- Reset, then respawn -> enemy_alive=17'h1FFFF, busy=0. frame_tick with no bullets active -> scan_done exactly 19 cycles later, bullet_hit=0, kill_count=0.
- Enemy 3 at (100,50); bullet 2 at (131,81), active; frame_tick -> bullet_hit=8'h04, kill_count=1, enemy_alive[3]=0. Repeat with the bullet at (132,81) -> no hit.
- HP_INIT=2; one bullet overlapping enemy 0 on two consecutive scans -> first scan: bullet_hit pulses and the enemy stays alive. Second scan: enemy_alive[0]=0, kill_count=1.
- Bullets 1 and 5 both overlap enemy 7 only -> bullet_hit=8'h02 and bullet 5 stays unconsumed. Add enemy 9 also overlapping bullet 5 -> bullet_hit=8'h22, kill_count=2.
- Enemy at x=1000 (COORD_W=10); bullet at x=5 -> no hit, so the sum does not wrap. Bullet at x=1023 -> hit.
- frame_tick 5 cycles into a scan -> overrun=1, and that scan completes normally. Then respawn mid-scan -> no scan_done, busy=0, enemy_alive all ones, overrun=0.

Source files
------------

// File: rtl/enemy_hit_scanner_if.sv
// Bus between the collision engine and its neighbours: bullet/enemy positions in,
// alive mask, hit pulses and scan status out.
interface enemy_hit_scanner_if #(
    parameter int unsigned ENEMY_COUNT  = 17,
    parameter int unsigned BULLET_COUNT = 8,
    parameter int unsigned COORD_W      = 10
);
    logic                              frame_tick;
    logic                              respawn;
    logic [BULLET_COUNT*COORD_W-1:0]   bullet_x;
    logic [BULLET_COUNT*COORD_W-1:0]   bullet_y;
    logic [BULLET_COUNT-1:0]           bullet_active;
    logic [ENEMY_COUNT*COORD_W-1:0]    enemy_x;
    logic [ENEMY_COUNT*COORD_W-1:0]    enemy_y;
    logic [ENEMY_COUNT-1:0]            enemy_alive;
    logic [BULLET_COUNT-1:0]           bullet_hit;
    logic                              scan_done;
    logic [$clog2(ENEMY_COUNT+1)-1:0]  kill_count;
    logic                              busy;
    logic                              overrun;

    modport master (
        output frame_tick, respawn, bullet_x, bullet_y, bullet_active, enemy_x, enemy_y,
        input  enemy_alive, bullet_hit, scan_done, kill_count, busy, overrun
    );

    modport slave (
        input  frame_tick, respawn, bullet_x, bullet_y, bullet_active, enemy_x, enemy_y,
        output enemy_alive, bullet_hit, scan_done, kill_count, busy, overrun
    );
endinterface

// File: rtl/enemy_hit_scanner.sv
// Time-multiplexed bullet-vs-enemy collision engine: one enemy per clock against all
// snapshotted bullets, with per-enemy hit points and a per-scan kill count.
module enemy_hit_scanner #(
    parameter int unsigned ENEMY_COUNT  = 17,
    parameter int unsigned BULLET_COUNT = 8,
    parameter int unsigned COORD_W      = 10,
    parameter int unsigned ENEMY_W      = 32,
    parameter int unsigned ENEMY_H      = 32,
    parameter int unsigned HP_W         = 2,
    parameter int unsigned HP_INIT      = 1
) (
    input  logic               clk25,
    input  logic               reset_n,
    enemy_hit_scanner_if.slave bus
);
    localparam int unsigned IDX_W  = (ENEMY_COUNT > 1) ? $clog2(ENEMY_COUNT) : 1;
    localparam int unsigned KILL_W = $clog2(ENEMY_COUNT + 1);
    localparam int unsigned SUM_W  = COORD_W + 1;

    typedef enum logic [1:0] {IDLE, SNAP, SCAN, DONE} state_t;

    state_t                          r_state;
    state_t                          w_state_nxt;
    logic                            w_overrun_set;

    logic [IDX_W-1:0]                r_idx;
    logic [BULLET_COUNT*COORD_W-1:0] r_snap_x;
    logic [BULLET_COUNT*COORD_W-1:0] r_snap_y;
    logic [BULLET_COUNT-1:0]         r_snap_act;
    logic [BULLET_COUNT-1:0]         r_consumed;
    logic [BULLET_COUNT-1:0]         r_hit_acc;
    logic [KILL_W-1:0]               r_kill_acc;
    logic [ENEMY_COUNT-1:0]          r_alive;
    logic [HP_W-1:0]                 r_hp [ENEMY_COUNT];

    logic [BULLET_COUNT-1:0]         r_bullet_hit;
    logic                            r_scan_done;
    logic [KILL_W-1:0]               r_kill_count;
    logic                            r_busy;
    logic                            r_overrun;

    logic [COORD_W-1:0]              w_ex_arr [ENEMY_COUNT];
    logic [COORD_W-1:0]              w_ey_arr [ENEMY_COUNT];
    logic [SUM_W-1:0]                w_ex_lo, w_ex_hi, w_ey_lo, w_ey_hi;
    logic [BULLET_COUNT-1:0]         w_cand;
    logic [BULLET_COUNT-1:0]         w_win;
    logic                            w_test;
    logic                            w_hit;
    logic                            w_kill;
    logic [HP_W-1:0]                 w_hp_dec;
    logic [BULLET_COUNT-1:0]         w_hit_acc_nxt;
    logic [KILL_W-1:0]               w_kill_acc_nxt;

    // Live enemy position mux selected by the scan index
    always_comb begin
        for (int i = 0; i < int'(ENEMY_COUNT); i++) begin
            w_ex_arr[i] = bus.enemy_x[i*COORD_W +: COORD_W];
            w_ey_arr[i] = bus.enemy_y[i*COORD_W +: COORD_W];
        end
    end

    // Hitbox bounds at one extra bit so enemies near the coordinate maximum never wrap
    assign w_ex_lo = {1'b0, w_ex_arr[r_idx]};
    assign w_ey_lo = {1'b0, w_ey_arr[r_idx]};
    assign w_ex_hi = w_ex_lo + SUM_W'(ENEMY_W);
    assign w_ey_hi = w_ey_lo + SUM_W'(ENEMY_H);

    always_comb begin
        logic [SUM_W-1:0] v_bx;
        logic [SUM_W-1:0] v_by;
        w_cand = '0;
        v_bx   = '0;
        v_by   = '0;
        for (int j = 0; j < int'(BULLET_COUNT); j++) begin
            v_bx = {1'b0, r_snap_x[j*COORD_W +: COORD_W]};
            v_by = {1'b0, r_snap_y[j*COORD_W +: COORD_W]};
            w_cand[j] = r_snap_act[j] && !r_consumed[j] &&
                        (v_bx >= w_ex_lo) && (v_bx < w_ex_hi) &&
                        (v_by >= w_ey_lo) && (v_by < w_ey_hi);
        end
    end

    // Lowest-index candidate wins: isolate the least significant set bit
    assign w_test         = (r_state == SCAN) && r_alive[r_idx];
    assign w_win          = w_test ? (w_cand & (~w_cand + BULLET_COUNT'(1))) : '0;
    assign w_hit          = |w_win;
    assign w_hp_dec       = r_hp[r_idx] - HP_W'(1);
    assign w_kill         = w_hit && (w_hp_dec == '0);
    assign w_hit_acc_nxt  = r_hit_acc | w_win;
    assign w_kill_acc_nxt = r_kill_acc + KILL_W'(w_kill);

    always_comb begin
        w_state_nxt   = r_state;
        w_overrun_set = 1'b0;
        case (r_state)
            IDLE: if (bus.frame_tick) w_state_nxt = SNAP;
            SNAP: w_state_nxt = SCAN;
            SCAN: if (r_idx == IDX_W'(ENEMY_COUNT - 1)) w_state_nxt = DONE;
            DONE: w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        if ((r_state == SNAP || r_state == SCAN) && bus.frame_tick)
            w_overrun_set = 1'b1;
        // Respawn aborts any scan and swallows a simultaneous frame_tick
        if (bus.respawn) begin
            w_state_nxt   = IDLE;
            w_overrun_set = 1'b0;
        end
    end

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_ff @(posedge clk25 or negedge reset_n) begin
        if (!reset_n) begin
            r_idx        <= '0;
            r_snap_x     <= '0;
            r_snap_y     <= '0;
            r_snap_act   <= '0;
            r_consumed   <= '0;
            r_hit_acc    <= '0;
            r_kill_acc   <= '0;
            r_alive      <= '0;
            for (int i = 0; i < int'(ENEMY_COUNT); i++) r_hp[i] <= '0;
            r_bullet_hit <= '0;
            r_scan_done  <= 1'b0;
            r_kill_count <= '0;
            r_busy       <= 1'b0;
            r_overrun    <= 1'b0;
        end else begin
            r_scan_done  <= (w_state_nxt == DONE);
            r_busy       <= (w_state_nxt == SNAP) || (w_state_nxt == SCAN);
            r_bullet_hit <= (w_state_nxt == DONE) ? w_hit_acc_nxt : '0;
            if (w_state_nxt == DONE) r_kill_count <= w_kill_acc_nxt;

            if (bus.respawn)       r_overrun <= 1'b0;
            else if (w_overrun_set) r_overrun <= 1'b1;

            if (r_state == SNAP) begin
                r_snap_x   <= bus.bullet_x;
                r_snap_y   <= bus.bullet_y;
                r_snap_act <= bus.bullet_active;
                r_consumed <= '0;
                r_hit_acc  <= '0;
                r_kill_acc <= '0;
                r_idx      <= '0;
            end

            if (r_state == SCAN) begin
                r_idx      <= r_idx + IDX_W'(1);
                r_consumed <= r_consumed | w_win;
                r_hit_acc  <= w_hit_acc_nxt;
                r_kill_acc <= w_kill_acc_nxt;
                if (w_hit) begin
                    r_hp[r_idx] <= w_hp_dec;
                    if (w_kill) r_alive[r_idx] <= 1'b0;
                end
            end

            if (bus.respawn) begin
                r_alive <= '1;
                for (int i = 0; i < int'(ENEMY_COUNT); i++) r_hp[i] <= HP_W'(HP_INIT);
            end
        end
    end

    assign bus.enemy_alive = r_alive;
    assign bus.bullet_hit  = r_bullet_hit;
    assign bus.scan_done   = r_scan_done;
    assign bus.kill_count  = r_kill_count;
    assign bus.busy        = r_busy;
    assign bus.overrun     = r_overrun;

endmodule

// File: tb/tb_enemy_hit_scanner.sv
// Scoreboard bench: two scanners (HP_INIT=1 and HP_INIT=2) share stimulus and are
// checked against a per-scan behavioural model of hits, hit points and kills.
module tb_enemy_hit_scanner;
    localparam int NE = 17;
    localparam int NB = 8;
    localparam int CW = 10;
    localparam int EW = 32;
    localparam int EH = 32;
    localparam int KW = $clog2(NE + 1);

    typedef struct {
        logic [NB-1:0] hit;
        int            kill;
        logic [NE-1:0] alive;
        int            due;
    } exp_t;

    logic clk25   = 1'b0;
    logic reset_n = 1'b0;
    always #20 clk25 = ~clk25;

    int cyc = 0;
    always @(posedge clk25) cyc <= cyc + 1;

    enemy_hit_scanner_if #(.ENEMY_COUNT(NE), .BULLET_COUNT(NB), .COORD_W(CW)) bus0 ();
    enemy_hit_scanner_if #(.ENEMY_COUNT(NE), .BULLET_COUNT(NB), .COORD_W(CW)) bus1 ();

    enemy_hit_scanner #(.ENEMY_COUNT(NE), .BULLET_COUNT(NB), .COORD_W(CW), .ENEMY_W(EW),
                        .ENEMY_H(EH), .HP_W(2), .HP_INIT(1))
        dut0 (.clk25(clk25), .reset_n(reset_n), .bus(bus0));
    enemy_hit_scanner #(.ENEMY_COUNT(NE), .BULLET_COUNT(NB), .COORD_W(CW), .ENEMY_W(EW),
                        .ENEMY_H(EH), .HP_W(2), .HP_INIT(2))
        dut1 (.clk25(clk25), .reset_n(reset_n), .bus(bus1));

    logic              t_tick = 1'b0;
    logic              t_resp = 1'b0;
    logic [NB*CW-1:0]  t_bx = '0, t_by = '0;
    logic [NB-1:0]     t_bact = '0;
    logic [NE*CW-1:0]  t_ex = '0, t_ey = '0;

    assign bus0.frame_tick = t_tick;  assign bus1.frame_tick = t_tick;
    assign bus0.respawn    = t_resp;  assign bus1.respawn    = t_resp;
    assign bus0.bullet_x   = t_bx;    assign bus1.bullet_x   = t_bx;
    assign bus0.bullet_y   = t_by;    assign bus1.bullet_y   = t_by;
    assign bus0.bullet_active = t_bact; assign bus1.bullet_active = t_bact;
    assign bus0.enemy_x    = t_ex;    assign bus1.enemy_x    = t_ex;
    assign bus0.enemy_y    = t_ey;    assign bus1.enemy_y    = t_ey;

    int bx[NB], by[NB], ex[NE], ey[NE];
    bit bact[NB];

    bit m_alive[2][NE];
    int m_hp[2][NE];
    int m_last_kill[2];
    bit m_over[2];
    int hp_init[2] = '{1, 2};

    exp_t q0[$];
    exp_t q1[$];
    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp_v);
        n_chk++;
        if (act !== exp_v) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp_v, cyc);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk25);
        #1;
    endtask

    task automatic pack();
        for (int j = 0; j < NB; j++) begin
            t_bx[j*CW +: CW] = CW'(bx[j]);
            t_by[j*CW +: CW] = CW'(by[j]);
            t_bact[j]        = bact[j];
        end
        for (int i = 0; i < NE; i++) begin
            t_ex[i*CW +: CW] = CW'(ex[i]);
            t_ey[i*CW +: CW] = CW'(ey[i]);
        end
    endtask

    // One frame: each alive enemy in order takes the first free overlapping bullet
    task automatic model_scan(input int d, output exp_t e);
        bit used[NB];
        for (int j = 0; j < NB; j++) used[j] = 1'b0;
        e.hit  = '0;
        e.kill = 0;
        for (int i = 0; i < NE; i++) begin
            if (m_alive[d][i]) begin
                for (int j = 0; j < NB; j++) begin
                    if (bact[j] && !used[j] && bx[j] >= ex[i] && bx[j] < ex[i] + EW &&
                        by[j] >= ey[i] && by[j] < ey[i] + EH) begin
                        used[j]    = 1'b1;
                        e.hit[j]   = 1'b1;
                        m_hp[d][i] = m_hp[d][i] - 1;
                        if (m_hp[d][i] == 0) begin
                            m_alive[d][i] = 1'b0;
                            e.kill++;
                        end
                        break;
                    end
                end
            end
        end
        for (int i = 0; i < NE; i++) e.alive[i] = m_alive[d][i];
        e.due = cyc + NE + 2;
    endtask

    task automatic tick();
        exp_t e;
        model_scan(0, e); q0.push_back(e);
        model_scan(1, e); q1.push_back(e);
        t_tick = 1'b1;
        step(1);
        t_tick = 1'b0;
    endtask

    task automatic tick_busy();
        m_over[0] = 1'b1;
        m_over[1] = 1'b1;
        t_tick = 1'b1;
        step(1);
        t_tick = 1'b0;
    endtask

    task automatic model_respawn();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NE; i++) begin
                m_alive[d][i] = 1'b1;
                m_hp[d][i]    = hp_init[d];
            end
            m_over[d] = 1'b0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic do_respawn();
        model_respawn();
        t_resp = 1'b1;
        step(1);
        t_resp = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        logic [NE-1:0] a0, a1;
        for (int i = 0; i < NE; i++) begin
            a0[i] = m_alive[0][i];
            a1[i] = m_alive[1][i];
        end
        chk({tag, " d0 busy"}, bus0.busy, 0);
        chk({tag, " d1 busy"}, bus1.busy, 0);
        chk({tag, " d0 alive"}, bus0.enemy_alive, a0);
        chk({tag, " d1 alive"}, bus1.enemy_alive, a1);
        chk({tag, " d0 overrun"}, bus0.overrun, m_over[0]);
        chk({tag, " d1 overrun"}, bus1.overrun, m_over[1]);
        chk({tag, " d0 kill_count"}, bus0.kill_count, m_last_kill[0]);
        chk({tag, " d1 kill_count"}, bus1.kill_count, m_last_kill[1]);
    endtask

    task automatic run_scan(input string tag);
        tick();
        chk({tag, " busy"}, bus0.busy, 1);
        step(NE + 3);
        chk_idle(tag);
    endtask

    task automatic mon(input int d, input logic sd, input logic [NB-1:0] bh,
                       input logic [KW-1:0] kc, input logic [NE-1:0] al);
        exp_t e;
        bit   have;
        have = (d == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) e = (d == 0) ? q0[0] : q1[0];
        if (sd) begin
            if (!have) begin
                chk($sformatf("d%0d unexpected scan_done", d), sd, 0);
            end else begin
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
                chk($sformatf("d%0d scan_done cycle", d), cyc, e.due);
                chk($sformatf("d%0d bullet_hit", d), bh, e.hit);
                chk($sformatf("d%0d kill_count", d), kc, e.kill);
                chk($sformatf("d%0d enemy_alive", d), al, e.alive);
                m_last_kill[d] = e.kill;
            end
        end else begin
            if (bh != '0) chk($sformatf("d%0d bullet_hit outside DONE", d), bh, 0);
            if (have && cyc > e.due) begin
                chk($sformatf("d%0d scan_done timeout", d), sd, 1);
                if (d == 0) void'(q0.pop_front()); else void'(q1.pop_front());
            end
        end
    endtask

    always @(negedge clk25) begin
        if (reset_n) begin
            mon(0, bus0.scan_done, bus0.bullet_hit, bus0.kill_count, bus0.enemy_alive);
            mon(1, bus1.scan_done, bus1.bullet_hit, bus1.kill_count, bus1.enemy_alive);
        end
    end

    task automatic default_field();
        for (int i = 0; i < NE; i++) begin
            ex[i] = i * 50;
            ey[i] = 600;
        end
        for (int j = 0; j < NB; j++) begin
            bx[j] = 0; by[j] = 0; bact[j] = 1'b0;
        end
        pack();
    endtask

    initial begin
        default_field();
        step(2);
        reset_n = 1'b1;
        step(1);
        chk_idle("reset");
        chk("reset scan_done", bus0.scan_done, 0);

        do_respawn();
        chk("respawn alive", bus0.enemy_alive, 17'h1FFFF);
        chk_idle("respawn");
        run_scan("empty");

        ex[3] = 100; ey[3] = 50;
        bx[2] = 131; by[2] = 81; bact[2] = 1'b1;
        pack();
        run_scan("corner hit");
        chk("corner enemy3 dead", bus0.enemy_alive[3], 0);
        run_scan("second hit hp2");
        chk("hp2 enemy3 dead", bus1.enemy_alive[3], 0);

        do_respawn();
        bx[2] = 132;
        pack();
        run_scan("edge miss");

        do_respawn();
        default_field();
        ex[7] = 300; ey[7] = 100;
        bx[1] = 305; by[1] = 105; bact[1] = 1'b1;
        bx[5] = 310; by[5] = 110; bact[5] = 1'b1;
        pack();
        run_scan("priority");
        do_respawn();
        ex[9] = 305; ey[9] = 105;
        pack();
        run_scan("priority two enemies");

        do_respawn();
        default_field();
        ex[0] = 1000; ey[0] = 200;
        bx[0] = 5; by[0] = 210; bact[0] = 1'b1;
        pack();
        run_scan("no wrap");
        bx[0] = 1023;
        pack();
        run_scan("coord max hit");

        do_respawn();
        tick();
        step(4);
        tick_busy();
        chk("overrun set", bus0.overrun, 1);
        step(NE + 3);
        chk_idle("after overrun");

        tick();
        step(8);
        do_respawn();
        chk_idle("respawn abort");
        step(NE + 5);
        chk_idle("abort quiet");

        model_respawn();
        t_tick = 1'b1; t_resp = 1'b1;
        step(1);
        t_tick = 1'b0; t_resp = 1'b0;
        step(NE + 5);
        chk_idle("respawn with tick");

        tick();
        step(4);
        reset_n = 1'b0;
        #1;
        q0.delete(); q1.delete();
        for (int d = 0; d < 2; d++) begin
            for (int i = 0; i < NE; i++) begin
                m_alive[d][i] = 1'b0;
                m_hp[d][i]    = 0;
            end
            m_over[d] = 1'b0;
            m_last_kill[d] = 0;
        end
        chk_idle("reset mid scan");
        step(1);
        reset_n = 1'b1;
        do_respawn();

        for (int it = 0; it < 40; it++) begin
            if ($urandom_range(3) == 0) do_respawn();
            for (int i = 0; i < NE; i++) begin
                ex[i] = (i == 16) ? $urandom_range(960, 1023) : $urandom_range(0, 200);
                ey[i] = $urandom_range(0, 200);
            end
            for (int j = 0; j < NB; j++) begin
                bx[j]   = (j == 7) ? $urandom_range(980, 1023) : $urandom_range(0, 240);
                by[j]   = $urandom_range(0, 240);
                bact[j] = 1'($urandom);
            end
            pack();
            run_scan("random");
        end

        step(3);
        chk("queue0 drained", q0.size(), 0);
        chk("queue1 drained", q1.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
